jtopl_pg_acc: RTL and testbench

//  Sequential phase accumulator around the combinational phase stage (jtopl_pg_comb interface).

---
 rtl/jtopl_pg_pkg.sv | 16 +
 rtl/jtopl_pg_acc_if.sv | 27 ++
 rtl/jtopl_pg_store.sv | 48 ++++
 rtl/jtopl_pg_acc.sv | 60 ++++++
 tb/tb_jtopl_pg_acc.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/jtopl_pg_pkg.sv
// Shared sizes and helpers for the phase accumulator slice.
// Included by jtopl_pg_acc_if, jtopl_pg_store and jtopl_pg_acc.
package jtopl_pg_pkg;
   localparam int SLOTS = 18;
   localparam int PHW   = 20;
   localparam int INCW  = 17;
   localparam int SW    = 5;

   localparam logic [SW-1:0] LAST = 5'(SLOTS - 1);

   function automatic logic [SW-1:0] next_slot(
      input logic [SW-1:0] s
   );
      return (s == LAST) ? '0 : s + 5'd1;
   endfunction
endpackage

// File: rtl/jtopl_pg_acc_if.sv
// Link between the phase accumulator and the sum stage.
// master = accumulator side, slave = sum stage side.
interface jtopl_pg_acc_if;
   import jtopl_pg_pkg::*;

   logic [INCW-1:0] phinc_II;
   logic [PHW-1:0]  phase_II;
   logic            pg_rst_II;
   logic [PHW-1:0]  phase_out_II;
   logic [9:0]      phase_op_II;

   modport master (
      output phinc_II,
      output phase_II,
      output pg_rst_II,
      input  phase_out_II,
      input  phase_op_II
   );

   modport slave (
      input  phinc_II,
      input  phase_II,
      input  pg_rst_II,
      output phase_out_II,
      output phase_op_II
   );
endinterface

// File: rtl/jtopl_pg_store.sv
// SLOTS x PHW circulating phase store with head, tail and optional peek.
// Peek read mux exists only when JTOPL_PG_PEEK_EN is defined.
module jtopl_pg_store
   import jtopl_pg_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   input  logic           cen,
   input  logic [PHW-1:0] tail,
   output logic [PHW-1:0] head,
   input  logic [SW-1:0]  slot_II,
   input  logic [SW-1:0]  peek_slot,
   output logic [PHW-1:0] peek_phase
);
   logic [PHW-1:0] mem [SLOTS];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < SLOTS; i++)
            mem[i] <= '0;
      end else if (cen) begin
         for (int i = 0; i < SLOTS - 1; i++)
            mem[i] <= mem[i+1];
         mem[SLOTS-1] <= tail;
      end
   end

   assign head = mem[0];

`ifdef JTOPL_PG_PEEK_EN
   // mem[i] holds slot (slot_II + i) mod SLOTS
   logic [SW:0] off;

   always_comb begin
      peek_phase = '0;
      off = {1'b0, peek_slot} + 6'(SLOTS)
          - {1'b0, slot_II};
      if (off >= 6'(SLOTS))
         off = off - 6'(SLOTS);
      if ({1'b0, peek_slot} < 6'(SLOTS))
         peek_phase = mem[off[SW-1:0]];
   end
`else
   logic unused_peek;
   assign unused_peek = ^{peek_slot, slot_II};
   assign peek_phase  = '0;
`endif
endmodule

// File: rtl/jtopl_pg_acc.sv
// Phase accumulator around the sum stage: slot counter, key-on edges, store.
// Optional debug read port enabled by JTOPL_PG_PEEK_EN.
module jtopl_pg_acc
   import jtopl_pg_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            cen,
   input  logic            zero,
   input  logic            keyon_I,
   input  logic [INCW-1:0] phinc_I,
   jtopl_pg_acc_if.master  pg,
   output logic [9:0]      phase_op_III,
   output logic [SW-1:0]   slot_II,
   output logic            sync_err,
   input  logic [SW-1:0]   peek_slot,
   output logic [PHW-1:0]  peek_phase
);
   logic [SW-1:0]    cnt;
   logic [SW-1:0]    slot_I;
   logic [SLOTS-1:0] kon_hist;
   logic [PHW-1:0]   head;

   // zero resyncs stage I to slot 0 in the same cycle
   assign slot_I = zero ? '0 : cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt          <= '0;
         kon_hist     <= '0;
         sync_err     <= 1'b0;
         slot_II      <= '0;
         phase_op_III <= '0;
         pg.phinc_II  <= '0;
         pg.pg_rst_II <= 1'b0;
      end else if (cen) begin
         cnt <= next_slot(slot_I);
         if (zero && cnt != '0)
            sync_err <= 1'b1;
         pg.pg_rst_II     <= keyon_I & ~kon_hist[slot_I];
         kon_hist[slot_I] <= keyon_I;
         pg.phinc_II      <= phinc_I;
         slot_II          <= slot_I;
         phase_op_III     <= pg.phase_op_II;
      end
   end

   jtopl_pg_store u_store (
      .clk        (clk),
      .rst        (rst),
      .cen        (cen),
      .tail       (pg.phase_out_II),
      .head       (head),
      .slot_II    (slot_II),
      .peek_slot  (peek_slot),
      .peek_phase (peek_phase)
   );

   assign pg.phase_II = head;
endmodule

// File: tb/tb_jtopl_pg_acc.sv
// Self-checking bench for jtopl_pg_acc: per-slot model plus directed checks.
// Build with or without JTOPL_PG_PEEK_EN.
module tb_jtopl_pg_acc;
   logic        clk = 1'b0;
   logic        rst;
   logic        cen = 1'b0;
   logic        zero = 1'b0;
   logic        keyon_I = 1'b0;
   logic [16:0] phinc_I = '0;
   logic [9:0]  phase_op_III;
   logic [4:0]  slot_II;
   logic        sync_err;
   logic [4:0]  peek_slot = 5'd4;
   logic [19:0] peek_phase;

   jtopl_pg_acc_if pg();

   jtopl_pg_acc dut (
      .clk          (clk),
      .rst          (rst),
      .cen          (cen),
      .zero         (zero),
      .keyon_I      (keyon_I),
      .phinc_I      (phinc_I),
      .pg           (pg),
      .phase_op_III (phase_op_III),
      .slot_II      (slot_II),
      .sync_err     (sync_err),
      .peek_slot    (peek_slot),
      .peek_phase   (peek_phase)
   );

   // sum stage stand-in
   logic [19:0] sum_out;
   always_comb begin
      sum_out = pg.pg_rst_II ? 20'd0
              : pg.phase_II + {3'b0, pg.phinc_II};
      pg.phase_out_II = sum_out;
      pg.phase_op_II  = sum_out[19:10];
   end

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   bit run   = 0;

   logic [19:0] m_phase [18];
   bit          m_kon   [18];
   int          m_cnt, m_slot2;
   bit          m_pg, m_err, chk_ph;
   logic [16:0] m_phinc;
   logic [9:0]  m_op3;

   task automatic chk(string nm, logic [31:0] a,
                      logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %0h want %0h t=%0t",
                  nm, a, e, $time);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 18; i++) begin
         m_phase[i] = '0;
         m_kon[i]   = 0;
      end
      m_cnt = 0; m_slot2 = 0; m_pg = 0; m_err = 0;
      m_phinc = '0; m_op3 = '0; chk_ph = 1;
   endtask

   task automatic model_edge();
      logic [19:0] o;
      int s;
      if (rst || !cen) return;
      o = m_pg ? 20'd0 : m_phase[m_slot2] + 20'(m_phinc);
      m_phase[m_slot2] = o;
      m_op3 = o[19:10];
      s = zero ? 0 : m_cnt;
      if (zero && m_cnt != 0) begin
         m_err  = 1;
         chk_ph = 0;
      end
      m_pg    = keyon_I & !m_kon[s];
      m_kon[s] = keyon_I;
      m_phinc = phinc_I;
      m_slot2 = s;
      m_cnt   = (s == 17) ? 0 : s + 1;
   endtask

   task automatic step(bit c, bit k, logic [16:0] inc,
                       bit desync = 0);
      cen     = c;
      keyon_I = k;
      phinc_I = inc;
      zero    = desync ? 1'b1 : (m_cnt == 0);
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic rounds(int n, logic [16:0] inc);
      for (int r = 0; r < n; r++)
         for (int i = 0; i < 18; i++)
            step(1, 0, inc);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      model_clear();
      for (int i = 0; i < 4; i++) step(i[0], 0, 17'h1);
      chk("rst_slot", 32'(slot_II), 0);
      chk("rst_err", 32'(sync_err), 0);
      chk("rst_phase", 32'(pg.phase_II), 0);
      chk("rst_pgrst", 32'(pg.pg_rst_II), 0);
      chk("rst_op", 32'(phase_op_III), 0);
      chk("rst_peek", 32'(peek_phase), 0);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) step(0, 0, 17'h0);
      chk("hold_slot", 32'(slot_II), 0);
      chk("hold_phinc", 32'(pg.phinc_II), 0);
   endtask

   always @(negedge clk) begin
      if (run) begin
         chk("slot_II", 32'(slot_II), 32'(m_slot2));
         chk("phinc_II", 32'(pg.phinc_II), 32'(m_phinc));
         chk("pg_rst_II", 32'(pg.pg_rst_II), 32'(m_pg));
         chk("sync_err", 32'(sync_err), 32'(m_err));
         if (chk_ph) begin
            logic [19:0] ep;
            chk("phase_II", 32'(pg.phase_II),
                32'(m_phase[m_slot2]));
            chk("phase_op", 32'(phase_op_III), 32'(m_op3));
`ifdef JTOPL_PG_PEEK_EN
            ep = (peek_slot < 5'd18) ? m_phase[peek_slot] : 20'd0;
`else
            ep = 20'd0;
`endif
            chk("peek", 32'(peek_phase), 32'(ep));
         end
      end
   end

   initial begin
      rst = 1'b1;
      model_clear();
      run = 1;
      do_reset();

      rounds(5, 17'h00100);
      for (int i = 0; i < 18; i++) begin
         step(1, 0, 17'h00100);
         chk("acc500", 32'(pg.phase_II), 32'h00500);
      end

      do_reset();
      for (int r = 1; r <= 5; r++)
         for (int i = 0; i < 18; i++) begin
            step(1, (i == 4 && r >= 3), 17'h00100);
            if (i == 4 && r == 3)
               chk("kon_pg_r3", 32'(pg.pg_rst_II), 1);
            if (i == 5 && r == 3)
               chk("kon_pg_s5", 32'(pg.pg_rst_II), 0);
            if (i == 4 && r == 4) begin
               chk("kon_pg_r4", 32'(pg.pg_rst_II), 0);
               chk("kon_ph_r4", 32'(pg.phase_II), 0);
            end
            if (i == 4 && r == 5)
               chk("kon_ph_r5", 32'(pg.phase_II), 32'h00100);
         end

      do_reset();
      rounds(9, 17'h1FFFF);
      for (int i = 0; i < 18; i++) begin
         step(1, 0, 17'h1FFFF);
         chk("wrap", 32'(pg.phase_II), 32'h1FFF7);
      end

      do_reset();
      rounds(1, 17'h00020);
      for (int i = 0; i < 7; i++) step(1, 0, 17'h00020);
      chk("pre_desync_err", 32'(sync_err), 0);
      step(1, 0, 17'h00020, 1);
      chk("desync_slot", 32'(slot_II), 0);
      chk("desync_err", 32'(sync_err), 1);
      for (int i = 0; i < 30; i++) step(1, 0, 17'h00020);
      chk("sticky_err", 32'(sync_err), 1);
      do_reset();
      chk("err_cleared", 32'(sync_err), 0);

      peek_slot = 5'd4;
      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 99) < 30,
              1'($urandom_range(0, 1)),
              17'($urandom));
      peek_slot = 5'd20;
      step(1, 0, 17'h3);
      chk("peek_oob", 32'(peek_phase), 0);
      peek_slot = 5'd4;
      for (int i = 0; i < 40; i++)
         step($urandom_range(0, 99) < 30, 0, 17'h00abc);

      run = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
